// File: rtl/usb_tx_arbiter.sv
// Round-robin packet arbiter feeding the shared USB TX FIFO write port; each packet gets a channel header byte.
// Optional byte-count trailer after each packet when USB_TX_TRAILER_EN is defined.
module usb_tx_arbiter #(
  parameter int          NUM_CH      = 4,
  parameter int          TIMEOUT_CYC = 255,
  parameter logic [3:0]  HDR_TAG     = 4'hA,
  localparam int         CH_W        = $clog2(NUM_CH)
) (
  input  logic                  clk_pll,
  input  logic                  reset,
  input  logic [NUM_CH*8-1:0]   req_data,
  input  logic [NUM_CH-1:0]     req_valid,
  input  logic [NUM_CH-1:0]     req_last,
  output logic [NUM_CH-1:0]     req_ready,
  output logic [7:0]            FIFO_input_data,
  output logic                  FIFO_push_data,
  input  logic                  FIFO_full,
  output logic                  busy,
  output logic [CH_W-1:0]       grant_id,
  output logic                  timeout_err
);

`ifdef USB_TX_TRAILER_EN
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_DATA    = 2'd2,
    ST_TRAILER = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_DATA    = 2'd2
  } state_t;
`endif

  state_t             state_r, state_nxt_s;
  logic [CH_W-1:0]    grant_id_r, grant_nxt_s;
  logic [CH_W-1:0]    last_grant_r, last_grant_nxt_s;
  logic [15:0]        stall_cnt_r, stall_cnt_nxt_s;
  logic               timeout_err_r, timeout_err_nxt_s;
`ifdef USB_TX_TRAILER_EN
  logic [7:0]         byte_cnt_r, byte_cnt_nxt_s;
`endif

  logic               sel_found_s;
  logic [CH_W-1:0]    sel_idx_s;
  logic [CH_W:0]      cand_s;

  logic               g_valid_s;
  logic               g_last_s;
  logic [7:0]         g_data_s;
  logic [3:0]         gid_nib_s;

  logic               push_s;
  logic [NUM_CH-1:0]  ready_s;
  logic [7:0]         fifo_data_s;

  assign g_valid_s = req_valid[grant_id_r];
  assign g_last_s  = req_last[grant_id_r];
  assign g_data_s  = req_data[{grant_id_r, 3'b000} +: 8];
  assign gid_nib_s = 4'(grant_id_r);

  // Round-robin search: first valid channel starting just above the last granted one.
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = last_grant_r;
    cand_s      = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand_s = {1'b0, last_grant_r} + (CH_W+1)'(i);
      cand_s = (cand_s >= (CH_W+1)'(NUM_CH)) ? (cand_s - (CH_W+1)'(NUM_CH)) : cand_s;
      if (!sel_found_s && req_valid[cand_s[CH_W-1:0]]) begin
        sel_found_s = 1'b1;
        sel_idx_s   = cand_s[CH_W-1:0];
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // FIFO write port and per-channel ready, decoded from the current state.
  always_comb begin
    push_s      = 1'b0;
    ready_s     = '0;
    fifo_data_s = 8'h00;
    case (state_r)
      ST_HEADER: begin
        fifo_data_s = {HDR_TAG, gid_nib_s};
        push_s      = !FIFO_full;
      end
      ST_DATA: begin
        fifo_data_s           = g_data_s;
        push_s                = g_valid_s && !FIFO_full;
        ready_s[grant_id_r]   = !FIFO_full;
      end
`ifdef USB_TX_TRAILER_EN
      ST_TRAILER: begin
        fifo_data_s = byte_cnt_r;
        push_s      = !FIFO_full;
      end
`endif
      default: begin
        push_s      = 1'b0;
      end
    endcase
  end

  // Next-state, grant bookkeeping and stall watchdog.
  always_comb begin
    state_nxt_s       = state_r;
    grant_nxt_s       = grant_id_r;
    last_grant_nxt_s  = last_grant_r;
    stall_cnt_nxt_s   = stall_cnt_r;
    timeout_err_nxt_s = timeout_err_r;
`ifdef USB_TX_TRAILER_EN
    byte_cnt_nxt_s    = byte_cnt_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (sel_found_s) begin
          grant_nxt_s     = sel_idx_s;
          state_nxt_s     = ST_HEADER;
          stall_cnt_nxt_s = 16'd0;
`ifdef USB_TX_TRAILER_EN
          byte_cnt_nxt_s  = 8'd0;
`endif
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_HEADER: begin
        if (push_s) begin
          state_nxt_s = ST_DATA;
        end else begin
          state_nxt_s = ST_HEADER;
        end
      end
      ST_DATA: begin
        if (push_s) begin
          stall_cnt_nxt_s = 16'd0;
`ifdef USB_TX_TRAILER_EN
          byte_cnt_nxt_s  = byte_cnt_r + 8'd1;
`endif
          if (g_last_s) begin
            last_grant_nxt_s = grant_id_r;
`ifdef USB_TX_TRAILER_EN
            state_nxt_s      = ST_TRAILER;
`else
            state_nxt_s      = ST_IDLE;
`endif
          end else begin
            state_nxt_s = ST_DATA;
          end
        end else if (!g_valid_s) begin
          // The stall that brings the count to TIMEOUT_CYC aborts in the same cycle.
          if (({1'b0, stall_cnt_r} + 17'd1) >= 17'(TIMEOUT_CYC)) begin
            timeout_err_nxt_s = 1'b1;
            last_grant_nxt_s  = grant_id_r;
            stall_cnt_nxt_s   = 16'd0;
            state_nxt_s       = ST_IDLE;
          end else begin
            stall_cnt_nxt_s = stall_cnt_r + 16'd1;
          end
        end else begin
          stall_cnt_nxt_s = stall_cnt_r;
        end
      end
`ifdef USB_TX_TRAILER_EN
      ST_TRAILER: begin
        if (push_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_TRAILER;
        end
      end
`endif
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and bookkeeping registers with synchronous reset.
  always_ff @(posedge clk_pll) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      grant_id_r    <= CH_W'(NUM_CH - 1);
      last_grant_r  <= CH_W'(NUM_CH - 1);
      stall_cnt_r   <= 16'd0;
      timeout_err_r <= 1'b0;
`ifdef USB_TX_TRAILER_EN
      byte_cnt_r    <= 8'd0;
`endif
    end else begin
      state_r       <= state_nxt_s;
      grant_id_r    <= grant_nxt_s;
      last_grant_r  <= last_grant_nxt_s;
      stall_cnt_r   <= stall_cnt_nxt_s;
      timeout_err_r <= timeout_err_nxt_s;
`ifdef USB_TX_TRAILER_EN
      byte_cnt_r    <= byte_cnt_nxt_s;
`endif
    end
  end

  assign req_ready       = ready_s;
  assign FIFO_push_data  = push_s;
  assign FIFO_input_data = fifo_data_s;
  assign busy            = (state_r != ST_IDLE);
  assign grant_id        = grant_id_r;
  assign timeout_err     = timeout_err_r;

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Bench for usb_tx_arbiter: directed scenarios plus a randomized run against a packet-order model.
module tb_usb_tx_arbiter;

  localparam int NCH = 4;

  logic            clk_pll = 1'b0;
  logic            reset   = 1'b1;
  logic [NCH*8-1:0] req_data  = '0;
  logic [NCH-1:0]  req_valid = '0;
  logic [NCH-1:0]  req_last  = '0;
  logic [NCH-1:0]  req_ready;
  logic [7:0]      FIFO_input_data;
  logic            FIFO_push_data;
  logic            FIFO_full = 1'b0;
  logic            busy;
  logic [1:0]      grant_id;
  logic            timeout_err;

  int total = 0;
  int bad   = 0;

  logic [7:0] src_data [NCH][$];
  bit         src_last [NCH][$];
  int         plen     [NCH][$];
  logic [7:0] exp_q [$];
  logic [7:0] hdr_q [$];
  bit         mid    [NCH];
  int         stalls [NCH];
  logic [NCH-1:0] rdy_smp;

  usb_tx_arbiter #(.NUM_CH(NCH), .TIMEOUT_CYC(4), .HDR_TAG(4'hA)) dut (
    .clk_pll(clk_pll), .reset(reset),
    .req_data(req_data), .req_valid(req_valid), .req_last(req_last), .req_ready(req_ready),
    .FIFO_input_data(FIFO_input_data), .FIFO_push_data(FIFO_push_data), .FIFO_full(FIFO_full),
    .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
  );

  always #5 clk_pll = ~clk_pll;

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk_pll); #1;
  endtask

  task automatic set_ch(input int k, input logic v, input logic [7:0] d, input logic l);
    req_valid[k]       = v;
    req_data[k*8 +: 8] = d;
    req_last[k]        = l;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = '0; req_last = '0; req_data = '0; FIFO_full = 1'b0;
    for (int k = 0; k < NCH; k++) begin mid[k] = 1'b0; stalls[k] = 0; end
    nxt(); nxt();
    reset = 1'b0;
  endtask

  // Expect one push of byte b in the current cycle, then advance.
  task automatic exp_push(input string tag, input logic [7:0] b);
    @(negedge clk_pll);
    chk(tag, {23'd0, FIFO_push_data, FIFO_input_data}, {23'd0, 1'b1, b});
    nxt();
  endtask

  task automatic exp_nopush(input string tag);
    @(negedge clk_pll);
    chk(tag, 32'(FIFO_push_data), 32'd0);
    nxt();
  endtask

  function automatic bit srcs_busy();
    bit r = 1'b0;
    for (int k = 0; k < NCH; k++) if (src_data[k].size() > 0) r = 1'b1;
    return r;
  endfunction

  // One randomized cycle: sources present head bytes (with short mid-packet gaps), FIFO_full random.
  task automatic rstep();
    logic [8:0] eb;
    for (int k = 0; k < NCH; k++) begin
      if (src_data[k].size() > 0) begin
        req_valid[k]       = !(mid[k] && stalls[k] < 2 && $urandom_range(0, 3) == 0);
        req_data[k*8 +: 8] = src_data[k][0];
        req_last[k]        = src_last[k][0];
      end else begin
        set_ch(k, 1'b0, 8'h00, 1'b0);
      end
    end
    FIFO_full = ($urandom_range(0, 3) == 0);
    @(negedge clk_pll);
    if (FIFO_full) chk("r_no_push_when_full", 32'(FIFO_push_data), 32'd0);
    if (FIFO_push_data) begin
      eb = (exp_q.size() > 0) ? {1'b0, exp_q.pop_front()} : 9'h100;
      chk("r_stream_byte", {23'd0, 1'b0, FIFO_input_data}, {23'd0, eb});
    end
    rdy_smp = req_ready;
    nxt();
    for (int k = 0; k < NCH; k++) begin
      if (req_valid[k] && rdy_smp[k]) begin
        mid[k]    = !src_last[k][0];
        stalls[k] = 0;
        void'(src_data[k].pop_front());
        void'(src_last[k].pop_front());
      end else if (mid[k] && !req_valid[k]) begin
        stalls[k]++;
      end
    end
  endtask

  initial begin
    int last, c, np, L, cyc;
    int ptr [NCH];
    int pk  [NCH];
    bit found;

    do_reset();
    @(negedge clk_pll);
    chk("rst_busy",    32'(busy), 32'd0);
    chk("rst_grant",   32'(grant_id), 32'd3);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    chk("rst_push",    32'(FIFO_push_data), 32'd0);
    chk("rst_ready",   32'(req_ready), 32'd0);
    chk("rst_data",    32'(FIFO_input_data), 32'd0);
    nxt();

    // Single 3-byte packet on channel 0.
    set_ch(0, 1'b1, 8'h11, 1'b0);
    exp_nopush("t1_idle");
    @(negedge clk_pll);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_grant", 32'(grant_id), 32'd0);
    nxt();
    // header already checked for grant; re-check header byte path via stream below
    @(negedge clk_pll);
    chk("t1_b0", {FIFO_push_data, FIFO_input_data}, {23'd0, 1'b1, 8'h11});
    chk("t1_ready", 32'(req_ready), 32'h1);
    nxt();
    set_ch(0, 1'b1, 8'h22, 1'b0);
    exp_push("t1_b1", 8'h22);
    set_ch(0, 1'b1, 8'h33, 1'b1);
    exp_push("t1_b2", 8'h33);
    set_ch(0, 1'b0, 8'h00, 1'b0);
`ifdef USB_TX_TRAILER_EN
    @(negedge clk_pll);
    chk("t1_trl_busy", 32'(busy), 32'd1);
    nxt();
`endif
    @(negedge clk_pll);
    chk("t1_busy_fall", 32'(busy), 32'd0);
    chk("t1_end_push", 32'(FIFO_push_data), 32'd0);
    nxt();

    // Header byte check for channel 0 on a fresh packet.
    do_reset();
    set_ch(0, 1'b1, 8'h44, 1'b1);
    exp_nopush("t1h_idle");
    exp_push("t1h_hdr", 8'hA0);
    exp_push("t1h_b", 8'h44);
    set_ch(0, 1'b0, 8'h00, 1'b0);
    repeat (3) nxt();

    // Channels 1 and 3 both request 1-byte packets continuously.
    do_reset();
    set_ch(1, 1'b1, 8'h51, 1'b1);
    set_ch(3, 1'b1, 8'h53, 1'b1);
    hdr_q.delete();
    for (int i = 0; i < 40 && hdr_q.size() < 4; i++) begin
      @(negedge clk_pll);
      if (FIFO_push_data && (FIFO_input_data == 8'hA1 || FIFO_input_data == 8'hA3))
        hdr_q.push_back(FIFO_input_data);
      nxt();
    end
    chk("t2_nhdr", 32'(hdr_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("t2_hdr", 32'(hdr_q[i]), (i % 2 == 0) ? 32'hA1 : 32'hA3);

    // FIFO_full held for 5 cycles while the granted byte is valid.
    do_reset();
    set_ch(0, 1'b1, 8'h5A, 1'b1);
    exp_nopush("t3_idle");
    exp_push("t3_hdr", 8'hA0);
    FIFO_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_pll);
      chk("t3_full_push", 32'(FIFO_push_data), 32'd0);
      chk("t3_full_ready", 32'(req_ready), 32'd0);
      nxt();
    end
    FIFO_full = 1'b0;
    @(negedge clk_pll);
    chk("t3_release", {FIFO_push_data, FIFO_input_data}, {23'd0, 1'b1, 8'h5A});
    chk("t3_ready", 32'(req_ready), 32'h1);
    nxt();
    set_ch(0, 1'b0, 8'h00, 1'b0);
`ifdef USB_TX_TRAILER_EN
    exp_push("t3_trailer", 8'h01);
`endif
    @(negedge clk_pll);
    chk("t3_no_dup", 32'(FIFO_push_data), 32'd0);
    chk("t3_timeout", 32'(timeout_err), 32'd0);
    nxt();

    // Channel 2 stalls mid-packet; channel 3 is waiting.
    do_reset();
    set_ch(2, 1'b1, 8'h77, 1'b0);
    set_ch(3, 1'b1, 8'h99, 1'b1);
    exp_nopush("t4_idle");
    exp_push("t4_hdr", 8'hA2);
    @(negedge clk_pll);
    chk("t4_b", {FIFO_push_data, FIFO_input_data}, {23'd0, 1'b1, 8'h77});
    chk("t4_ready", 32'(req_ready), 32'h4);
    nxt();
    set_ch(2, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_pll);
      chk("t4_stall_busy", 32'(busy), 32'd1);
      chk("t4_stall_err", 32'(timeout_err), 32'd0);
      chk("t4_stall_push", 32'(FIFO_push_data), 32'd0);
      nxt();
    end
    @(negedge clk_pll);
    chk("t4_err", 32'(timeout_err), 32'd1);
    chk("t4_idle_after", 32'(busy), 32'd0);
    nxt();
    exp_push("t4_hdr3", 8'hA3);
    exp_push("t4_b3", 8'h99);
    set_ch(3, 1'b0, 8'h00, 1'b0);
`ifdef USB_TX_TRAILER_EN
    exp_push("t4_trl3", 8'h01);
`endif

    // Reset during channel 0's DATA phase (timeout_err still set from above).
    set_ch(0, 1'b1, 8'h10, 1'b0);
    exp_nopush("t5_idle");
    exp_push("t5_hdr", 8'hA0);
    exp_push("t5_b", 8'h10);
    reset = 1'b1;
    nxt();
    reset = 1'b0;
    @(negedge clk_pll);
    chk("t5_push", 32'(FIFO_push_data), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_grant", 32'(grant_id), 32'd3);
    chk("t5_timeout", 32'(timeout_err), 32'd0);
    set_ch(1, 1'b1, 8'h20, 1'b1);
    nxt();
    @(negedge clk_pll);
    chk("t5_regrant", 32'(grant_id), 32'd0);
    nxt();

`ifdef USB_TX_TRAILER_EN
    // 257-byte packet: trailer wraps to 1.
    do_reset();
    set_ch(1, 1'b1, 8'h00, 1'b0);
    exp_nopush("t6_idle");
    exp_push("t6_hdr", 8'hA1);
    for (int i = 0; i < 257; i++) begin
      set_ch(1, 1'b1, 8'(i), (i == 256));
      exp_push("t6_data", 8'(i));
    end
    set_ch(1, 1'b0, 8'h00, 1'b0);
    exp_push("t6_trailer", 8'h01);
`endif

    // Randomized traffic: packets queued on all channels, checked against a round-robin packet model.
    do_reset();
    exp_q.delete();
    for (int k = 0; k < NCH; k++) begin
      src_data[k].delete(); src_last[k].delete(); plen[k].delete();
      ptr[k] = 0; pk[k] = 0;
      np = $urandom_range(1, 3);
      for (int p = 0; p < np; p++) begin
        L = $urandom_range(1, 6);
        plen[k].push_back(L);
        for (int b = 0; b < L; b++) begin
          src_data[k].push_back(8'($urandom));
          src_last[k].push_back(b == L - 1);
        end
      end
    end
    last = NCH - 1;
    forever begin
      found = 1'b0;
      c = 0;
      for (int j = 1; j <= NCH; j++) begin
        if (!found && pk[(last + j) % NCH] < plen[(last + j) % NCH].size()) begin
          found = 1'b1;
          c = (last + j) % NCH;
        end
      end
      if (!found) break;
      L = plen[c][pk[c]];
      exp_q.push_back(8'hA0 | 8'(c));
      for (int b = 0; b < L; b++) exp_q.push_back(src_data[c][ptr[c] + b]);
`ifdef USB_TX_TRAILER_EN
      exp_q.push_back(8'(L));
`endif
      ptr[c] += L;
      pk[c]++;
      last = c;
    end
    cyc = 0;
    while ((exp_q.size() > 0 || srcs_busy()) && cyc < 4000) begin
      rstep();
      cyc++;
    end
    chk("r_drained", 32'(exp_q.size()), 32'd0);
    chk("r_timeout", 32'(timeout_err), 32'd0);
    req_valid = '0; FIFO_full = 1'b0;
    nxt(); nxt();
    @(negedge clk_pll);
    chk("r_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
